// File: rtl/dmem_dump_arbiter.sv
// dmem_dump_arbiter
// -----------------
// Shares the single data-memory port between the pipeline MEM stage and a
// memory-dump sequencer. On a rising edge of dump_req (seen while idle) the
// pipeline is frozen. There is one drain cycle, and then every data-memory
// word is read in address order. Each word is streamed out as a registered
// dump beat. After the scan the memory port goes back to the CPU.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   dump_req              dump request (level, acted on at its rising edge)
//   cpu_memRead/Write,
//   cpu_addr/writeData    pipeline MEM-stage access
//   cpu_readData          load data back to the pipeline (pass-through)
//   stall                 freezes PC and pipeline registers
//   mem_*                 connection to the dmem instance
//   dump_valid/addr/data  registered dump beat
//   dump_done             one-cycle pulse on the cycle of the last beat
//   busy                  high whenever the sequencer is not idle
module dmem_dump_arbiter #(
  parameter int N     = 64,
  parameter int DEPTH = 64,
  parameter int IDXW  = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dump_req,
  input  logic         cpu_memRead,
  input  logic         cpu_memWrite,
  input  logic [N-1:0] cpu_addr,
  input  logic [N-1:0] cpu_writeData,
  output logic [N-1:0] cpu_readData,
  output logic         stall,
  output logic         mem_readEnable,
  output logic         mem_writeEnable,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_writeData,
  input  logic [N-1:0] mem_readData,
  output logic         dump_valid,
  output logic [N-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_done,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, DRAIN, SCAN, DONE} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            req_q;
  logic            start;
  logic            last_word;
  logic [N-1:0]    scan_addr;

  assign start     = dump_req & ~req_q;
  assign last_word = (idx == IDXW'(DEPTH - 1));
  assign scan_addr = {{(N-IDXW-3){1'b0}}, idx, 3'b000};

  assign cpu_readData = mem_readData;

  // The memory port mux is decoded straight from the state register. That
  // way the CPU write enable reaches dmem in the same cycle, and once the
  // sequencer leaves IDLE it is forced low with no added delay.
  always_comb begin
    mem_readEnable  = 1'b0;
    mem_writeEnable = 1'b0;
    mem_addr        = '0;
    mem_writeData   = '0;
    case (state)
      IDLE: begin
        mem_readEnable  = cpu_memRead;
        mem_writeEnable = cpu_memWrite;
        mem_addr        = cpu_addr;
        mem_writeData   = cpu_writeData;
      end
      SCAN: begin
        mem_readEnable = 1'b1;
        mem_addr       = scan_addr;
      end
      default: ;
    endcase
  end

  // Sequencer FSM. stall, busy and dump_done are registered here so they
  // change only at clock edges (or at reset). The CPU access in the cycle a
  // start is seen still goes through, because the state is still IDLE.
  // A request edge arriving outside IDLE is dropped. req_q keeps tracking
  // dump_req, so a held request cannot start a second scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      req_q      <= 1'b0;
      stall      <= 1'b0;
      busy       <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      req_q      <= dump_req;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= DRAIN;
            stall <= 1'b1;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          state <= SCAN;
          idx   <= '0;
        end
        SCAN: begin
          dump_valid <= 1'b1;
          dump_addr  <= scan_addr;
          dump_data  <= mem_readData;
          // The final beat and dump_done appear together in the DONE cycle.
          if (last_word) begin
            state     <= DONE;
            dump_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
          stall <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_dump_arbiter.md
Name: dmem_dump_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage and a memory-dump sequencer.
- On a dump request, freezes the pipeline and scans every data-memory word in address order, streaming each word on a debug port.
- After the scan, it returns the memory port to the CPU.
- Sits between the datapath DM_* signals and the dmem instance.

Parameters:
N, 64, data/address width of the CPU and memory ports
DEPTH, 64, number of 64-bit words in data memory
IDXW, 6, word-index width (log2 DEPTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
dump_req  in  1  request a full memory dump; level input, acted on at its rising edge
cpu_memRead  in  1  pipeline read enable
cpu_memWrite  in  1  pipeline write enable
cpu_addr  in  N  pipeline byte address
cpu_writeData  in  N  pipeline store data
cpu_readData  out  N  load data returned to pipeline
stall  out  1  freeze pipeline (PC and all pipeline registers hold)
mem_readEnable  out  1  to dmem memRead
mem_writeEnable  out  1  to dmem memWrite
mem_addr  out  N  byte address to dmem (dmem uses bits [IDXW+2:3])
mem_writeData  out  N  to dmem writeData
mem_readData  in  N  from dmem, combinational read
dump_valid  out  1  dump beat valid (registered)
dump_addr  out  N  byte address of dump beat (registered)
dump_data  out  N  word of dump beat (registered)
dump_done  out  1  one-cycle pulse when scan completes
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, idx=0, req_q=0.
  - stall, busy, dump_valid, dump_done = 0.
  - dump_addr, dump_data = 0.
  - Takes effect immediately, including mid-scan; no dump_done is produced for an aborted scan.
- Edge detect: req_q registers dump_req. A start is dump_req & ~req_q, sampled in IDLE only. Starts arriving outside IDLE are dropped. Holding dump_req high produces exactly one scan.
- cpu_readData = mem_readData at all times (combinational pass-through).
- IDLE:
  - mem_* driven from cpu_*, combinationally; stall=0.
  - The CPU access in the cycle a start is seen completes normally.
  - On start, go to DRAIN.
- DRAIN (1 cycle):
  - stall=1; mem_readEnable=0, mem_writeEnable=0. cpu_* is ignored.
  - Go to SCAN with idx=0.
- SCAN (DEPTH cycles):
  - stall=1; mem_readEnable=1; mem_writeEnable=0.
  - mem_addr = zero-extended {idx, 3'b000}; mem_writeData=0.
  - At each clock edge: dump_valid<=1, dump_addr<=mem_addr, dump_data<=mem_readData.
  - If idx==DEPTH-1, go to DONE; otherwise idx<=idx+1.
- DONE (1 cycle):
  - stall=1; mem enables 0; dump_done=1.
  - The final dump beat is visible this cycle.
  - Go to IDLE with idx=0. dump_valid<=0 at this edge.
- dump_valid is 0 in every cycle other than the DEPTH cycles following SCAN edges.
- CPU stores presented while stall=1 never reach memory. The pipeline must hold and replay them, so with the pipeline frozen, memory contents are unchanged by a dump.
- Timing: start seen at edge k →
  - stall high from cycle k+1 through k+DEPTH+2 (DEPTH+2 cycles in total);
  - dump beats in cycles k+3 … k+DEPTH+2;
  - dump_done in cycle k+DEPTH+2;
  - stall low from k+DEPTH+3.
- Index arithmetic is unsigned IDXW-bit. The DEPTH-1 compare prevents wrap-around; idx never increments past DEPTH-1.
- Implementation style: state encoding is free. Outputs that are combinational from state must be glitch-tolerant for dmem's synchronous write; no registered decode delay is allowed on mem_writeEnable.

Test Plan:
- Reset: hold reset=0 with random inputs → stall=0, busy=0, dump_valid=0, dump_done=0, dump_addr=0, dump_data=0; release → still IDLE.
- Pass-through: IDLE, cpu_memWrite=1, cpu_addr=0x10, cpu_writeData=0xAB → mem_writeEnable=1, mem_addr=0x10, mem_writeData=0xAB; next cycle a read of 0x10 returns cpu_readData=0xAB.
- Full dump: preload mem[i]=3*i, pulse dump_req for one cycle →
  - stall high for exactly 66 cycles;
  - 64 dump_valid beats with dump_addr=8*i, dump_data=3*i, i=0..63 in order;
  - dump_done high for exactly one cycle, coinciding with beat i=63 (addr 0x1F8, data 189).
- Blocked store: during SCAN drive cpu_memWrite=1, cpu_addr=0x40, cpu_writeData=0xFFFF → mem_writeEnable stays 0; after the dump, mem[8] still reads 24.
- Held request: keep dump_req=1 for 200 cycles → exactly one scan (64 beats, one dump_done); dropping it then re-raising it starts a second scan.
- Reset mid-scan: assert reset=0 during the beat for i=20 → stall, busy and dump_valid fall immediately, no dump_done; after release, a new dump_req produces a full scan starting at dump_addr=0.
